// File: rtl/fp_round_pack.sv
// Two-stage round-and-pack pipeline for an 8-bit {sign, exp[2:0], sig[3:0]} float.
// S1 rounds the extracted significand; S2 packs and holds the result for a valid/ready sink.
module fp_round_pack #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [2:0]       in_exp,
    input  logic [3:0]       in_sig,
    input  logic             in_round,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_fp,
    output logic [CNT_W-1:0] sat_count
);

    logic             s1_valid_q;
    logic             s1_sign_q;
    logic [2:0]       s1_exp_q;
    logic [3:0]       s1_sig_q;
    logic             s1_sat_q;

    logic             s2_valid_q;
    logic [7:0]       s2_fp_q;
    logic             s2_sat_q;

    logic [CNT_W-1:0] sat_count_q;
    logic [CNT_W-1:0] sat_count_d;

    logic             s1_advance;
    logic             s2_advance;
    logic             in_xfer;
    logic             out_xfer;

    logic [4:0]       round_sum;
    logic [2:0]       round_exp;
    logic [3:0]       round_sig;
    logic             round_sat;

    // Handshake: a stage moves when it is empty or its consumer takes its content.
    assign s2_advance = !s2_valid_q || out_ready;
    assign s1_advance = !s1_valid_q || s2_advance;
    assign in_ready   = s1_advance;
    assign in_xfer    = in_valid && in_ready;
    assign out_xfer   = s2_valid_q && out_ready;

    // Round-half-up on the dropped bit; carry out of the significand renormalises
    // to 1000 with exponent+1, or clamps to the largest magnitude at exp=7.
    always_comb begin
        round_sum = {1'b0, in_sig} + {4'b0000, in_round};
        round_exp = in_exp;
        round_sig = round_sum[3:0];
        round_sat = 1'b0;
        if (round_sum[4]) begin
            if (in_exp != 3'b111) begin
                round_exp = in_exp + 3'd1;
                round_sig = 4'b1000;
            end else begin
                round_exp = 3'b111;
                round_sig = 4'b1111;
                round_sat = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= 3'b000;
            s1_sig_q   <= 4'b0000;
            s1_sat_q   <= 1'b0;
        end else if (s1_advance) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q <= in_sign;
                s1_exp_q  <= round_exp;
                s1_sig_q  <= round_sig;
                s1_sat_q  <= round_sat;
            end
        end
    end

    // Data only reloads on a real S1 result so a drained stage keeps its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_fp_q    <= 8'h00;
            s2_sat_q   <= 1'b0;
        end else if (s2_advance) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_fp_q  <= {s1_sign_q, s1_exp_q, s1_sig_q};
                s2_sat_q <= s1_sat_q;
            end
        end
    end

    always_comb begin
        sat_count_d = sat_count_q;
        if (out_xfer && s2_sat_q && (sat_count_q != {CNT_W{1'b1}})) begin
            sat_count_d = sat_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count_q <= '0;
        end else begin
            sat_count_q <= sat_count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_fp    = s2_fp_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_fp_round_pack.sv
// Scoreboard bench for fp_round_pack: driver pushes hand-computed results on acceptance,
// a free-running monitor pops and compares on every output transfer.
module tb_fp_round_pack;

    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_sign;
    logic [2:0]       in_exp;
    logic [3:0]       in_sig;
    logic             in_round;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_fp;
    logic [CNT_W-1:0] sat_count;

    fp_round_pack #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_sig    (in_sig),
        .in_round  (in_round),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fp    (out_fp),
        .sat_count (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] fp;
        logic       sat;
        int         acc;
    } exp_t;

    typedef struct {
        logic       sign;
        logic [2:0] exp;
        logic [3:0] sig;
        logic       rnd;
        logic [7:0] fp;
        logic       sat;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[10];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int exp_sat = 0;
    int or_mode = 1;      // 0: out_ready low, 1: high, 2: random
    bit lat_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
            $display("check %s: got %0h ok", name, act);
        end else begin
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // One cycle: drive at negedge, leave the caller sampling 1 time unit before posedge.
    task automatic tick(input logic v, input logic s, input logic [2:0] e,
                        input logic [3:0] g, input logic r);
        @(negedge clk);
        in_valid = v;
        in_sign  = s;
        in_exp   = e;
        in_sig   = g;
        in_round = r;
        case (or_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
        #4;
    endtask

    task automatic send(input vec_t v);
        bit   done;
        exp_t item;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1'b1, v.sign, v.exp, v.sig, v.rnd);
            if (in_ready) begin
                item.fp  = v.fp;
                item.sat = v.sat;
                item.acc = cyc;
                exp_q.push_back(item);
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_total++;
            $display("FAIL accept_timeout: in_ready stayed 0 required 1");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            tick(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        end
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: %0d results pending required 0", exp_q.size());
        end
        tick(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    // Monitor: compares every output transfer and checks that held outputs stay stable.
    initial begin : monitor
        exp_t       e;
        bit         hold_prev;
        logic [7:0] prev_fp;
        hold_prev = 1'b0;
        prev_fp   = 8'h00;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    chk("hold_fp", {24'd0, out_fp}, {24'd0, prev_fp});
                    chk("hold_valid", {31'd0, out_valid}, 32'd1);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_out: got %0h required no output", out_fp);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_fp", {24'd0, out_fp}, {24'd0, e.fp});
                        if (lat_chk) chk("latency", cyc - e.acc, 32'd2);
                        if (e.sat && exp_sat < 3) exp_sat++;
                    end
                end
                hold_prev = out_valid && !out_ready;
                prev_fp   = out_fp;
            end
        end
    end

    initial begin : driver
        vec_t va, vb, vc, vs;
        tbl[0] = '{1'b0, 3'd3, 4'b1011, 1'b1, 8'h3C, 1'b0};
        tbl[1] = '{1'b0, 3'd2, 4'b1111, 1'b1, 8'h38, 1'b0};
        tbl[2] = '{1'b1, 3'd7, 4'b1111, 1'b1, 8'hFF, 1'b1};
        tbl[3] = '{1'b0, 3'd0, 4'b0000, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{1'b1, 3'd0, 4'b0000, 1'b0, 8'h80, 1'b0};
        tbl[5] = '{1'b0, 3'd5, 4'b1010, 1'b0, 8'h5A, 1'b0};
        tbl[6] = '{1'b1, 3'd6, 4'b1111, 1'b1, 8'hF8, 1'b0};
        tbl[7] = '{1'b0, 3'd7, 4'b1110, 1'b1, 8'h7F, 1'b0};
        tbl[8] = '{1'b0, 3'd7, 4'b1111, 1'b0, 8'h7F, 1'b0};
        tbl[9] = '{1'b0, 3'd7, 4'b1111, 1'b1, 8'h7F, 1'b1};
        va = '{1'b0, 3'd1, 4'b0001, 1'b0, 8'h11, 1'b0};
        vb = '{1'b1, 3'd2, 4'b0011, 1'b1, 8'hA4, 1'b0};
        vc = '{1'b0, 3'd4, 4'b1000, 1'b1, 8'h49, 1'b0};
        vs = '{1'b1, 3'd7, 4'b1111, 1'b1, 8'hFF, 1'b1};

        in_valid = 1'b0; in_sign = 1'b0; in_exp = 3'd0; in_sig = 4'd0; in_round = 1'b0;
        out_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_fp", {24'd0, out_fp}, 32'h00);
        chk("rst_sat_count", {30'd0, sat_count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #4;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Full-rate stream with out_ready held high: 2-cycle latency, back-to-back.
        or_mode = 1;
        lat_chk = 1'b1;
        for (int i = 0; i < 10; i++) send(tbl[i]);
        drain();
        lat_chk = 1'b0;
        chk("sat_count_a", {30'd0, sat_count}, 32'd2);

        // Backpressure: two results fill the pipe, a third is refused until out_ready rises.
        or_mode = 0;
        send(va);
        send(vb);
        tick(1'b1, vc.sign, vc.exp, vc.sig, vc.rnd);
        chk("in_ready_full", {31'd0, in_ready}, 32'd0);
        tick(1'b1, vc.sign, vc.exp, vc.sig, vc.rnd);
        chk("in_ready_full2", {31'd0, in_ready}, 32'd0);
        or_mode = 1;
        send(vc);
        chk("burst_valid_a", {31'd0, out_valid}, 32'd1);
        tick(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        chk("burst_valid_b", {31'd0, out_valid}, 32'd1);
        tick(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        chk("burst_valid_c", {31'd0, out_valid}, 32'd1);
        drain();

        // Random out_ready: ordering and hold-stable checks in the monitor.
        or_mode = 2;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 10; i++) send(tbl[i]);
        or_mode = 1;
        drain();
        chk("sat_count_c", {30'd0, sat_count}, exp_sat);

        // Reset with two results in flight discards them.
        or_mode = 0;
        send(tbl[2]);
        send(tbl[9]);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        exp_sat = 0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_sat_count", {30'd0, sat_count}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #4;
        chk("midrst_release_in_ready", {31'd0, in_ready}, 32'd1);
        or_mode = 1;
        repeat (5) tick(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        chk("midrst_no_stale", {31'd0, out_valid}, 32'd0);

        // Counter saturation at 2^CNT_W-1.
        lat_chk = 1'b1;
        for (int i = 0; i < 5; i++) send(vs);
        drain();
        lat_chk = 1'b0;
        chk("sat_count_max", {30'd0, sat_count}, 32'd3);
        chk("sat_count_model", {30'd0, sat_count}, exp_sat);
        repeat (3) tick(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        chk("sat_count_hold", {30'd0, sat_count}, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
